// File: rtl/vlan_cfg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : vlan_cfg_ctrl
//  Description : Shadow/active configuration store for the VLAN parser.
//                Software writes the shadow bank. A commit request copies
//                shadow to active only at a packet boundary of the snooped
//                parser input stream. The upstream tready is stalled for one
//                cycle so that the copy cannot race with a new packet.
//  Revision    : 1.0  - initial release
// ----------------------------------------------------------------------------
//  Ports
//    aclk, aresetn         clock, asynchronous active-low reset
//    cfg_wr_en/sel/id/data shadow write port (sel 0 = config, 1 = CAM)
//    cfg_wr_ready          writes accepted only while no commit is pending
//    cfg_commit            request shadow -> active copy
//    cfg_busy              commit pending
//    cfg_done              one-cycle pulse after the copy edge
//    cfg_commit_count      applied commits, wrapping 8-bit count
//    mon_tvalid/tready/tlast  snoop of the parser input handshake
//    gate_stall            upstream ANDs !gate_stall into parser tready
//    vlan_config_sel       lookup index from the parser
//    vlan_config_regs      active config entry at vlan_config_sel
//    vlan_cam_values       all active CAM entries, 17 bits each
// ============================================================================
module vlan_cfg_ctrl #(
    parameter int AXIS_ID_WIDTH = 4,
    localparam int NUM_AXIS_ID  = 2 ** AXIS_ID_WIDTH,
    localparam int EFF_ID_WIDTH = (AXIS_ID_WIDTH > 1) ? AXIS_ID_WIDTH : 1
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        cfg_wr_en,
    input  logic                        cfg_wr_sel,
    input  logic [EFF_ID_WIDTH-1:0]     cfg_wr_id,
    input  logic [17:0]                 cfg_wr_data,
    output logic                        cfg_wr_ready,
    input  logic                        cfg_commit,
    output logic                        cfg_busy,
    output logic                        cfg_done,
    output logic [7:0]                  cfg_commit_count,
    input  logic                        mon_tvalid,
    input  logic                        mon_tready,
    input  logic                        mon_tlast,
    output logic                        gate_stall,
    input  logic [EFF_ID_WIDTH-1:0]     vlan_config_sel,
    output logic [17:0]                 vlan_config_regs,
    output logic [17*NUM_AXIS_ID-1:0]   vlan_cam_values
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_PEND = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_do_commit;
    logic        w_hs;
    logic        w_wr_accept;
    logic        r_in_pkt;
    logic        r_done;
    logic [7:0]  r_count;

    logic [17:0] r_shadow_cfg [NUM_AXIS_ID];
    logic [16:0] r_shadow_cam [NUM_AXIS_ID];
    logic [17:0] r_active_cfg [NUM_AXIS_ID];
    logic [16:0] r_active_cam [NUM_AXIS_ID];

    assign w_hs        = mon_tvalid && mon_tready;
    assign w_wr_accept = cfg_wr_en && (r_state == S_IDLE);

    // ------------------------------------------------------------------
    // Commit FSM: next state and copy strobe
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_do_commit  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cfg_commit) begin
                    w_state_next = S_PEND;
                end
            end
            S_PEND: begin
                // A handshake in the stall cycle means upstream ignored
                // gate_stall; that beat may start a packet, so defer.
                if (!r_in_pkt && !w_hs) begin
                    w_do_commit  = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= S_IDLE;
            r_in_pkt <= 1'b0;
            r_done   <= 1'b0;
            r_count  <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_do_commit;
            if (w_do_commit) begin
                r_count <= r_count + 8'd1;
            end
            if (w_hs) begin
                r_in_pkt <= !mon_tlast;
            end
        end
    end

    // ------------------------------------------------------------------
    // Shadow and active banks
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_AXIS_ID; i++) begin
                r_shadow_cfg[i] <= 18'd0;
                r_shadow_cam[i] <= 17'd0;
                r_active_cfg[i] <= 18'd0;
                r_active_cam[i] <= 17'd0;
            end
        end else begin
            // A write is only accepted in IDLE and a copy only happens in
            // PEND, so shadow is never written on a copy edge.
            if (w_wr_accept) begin
                if (cfg_wr_sel) begin
                    r_shadow_cam[cfg_wr_id] <= cfg_wr_data[16:0];
                end else begin
                    r_shadow_cfg[cfg_wr_id] <= cfg_wr_data;
                end
            end
            if (w_do_commit) begin
                for (int i = 0; i < NUM_AXIS_ID; i++) begin
                    r_active_cfg[i] <= r_shadow_cfg[i];
                    r_active_cam[i] <= r_shadow_cam[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cfg_wr_ready     = (r_state == S_IDLE);
    assign cfg_busy         = (r_state == S_PEND);
    assign gate_stall       = (r_state == S_PEND) && !r_in_pkt;
    assign cfg_done         = r_done;
    assign cfg_commit_count = r_count;
    assign vlan_config_regs = r_active_cfg[vlan_config_sel];

    generate
        for (genvar gi = 0; gi < NUM_AXIS_ID; gi++) begin : g_cam
            assign vlan_cam_values[17*gi +: 17] = r_active_cam[gi];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_vlan_cfg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vlan_cfg_ctrl
//  Description : Directed self-checking bench for vlan_cfg_ctrl. Upstream is
//                modelled as obeying gate_stall.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_vlan_cfg_ctrl;

    localparam int AW = 4;
    localparam int N  = 16;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          cfg_wr_en;
    logic          cfg_wr_sel;
    logic [AW-1:0] cfg_wr_id;
    logic [17:0]   cfg_wr_data;
    logic          cfg_wr_ready;
    logic          cfg_commit;
    logic          cfg_busy;
    logic          cfg_done;
    logic [7:0]    cfg_commit_count;
    logic          mon_tvalid;
    logic          up_ready;
    logic          mon_tready;
    logic          mon_tlast;
    logic          gate_stall;
    logic [AW-1:0] vlan_config_sel;
    logic [17:0]   vlan_config_regs;
    logic [17*N-1:0] vlan_cam_values;

    int errors = 0;
    int checks = 0;

    assign mon_tready = up_ready && !gate_stall;

    always #5 aclk = ~aclk;

    vlan_cfg_ctrl #(.AXIS_ID_WIDTH(AW)) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .cfg_wr_en        (cfg_wr_en),
        .cfg_wr_sel       (cfg_wr_sel),
        .cfg_wr_id        (cfg_wr_id),
        .cfg_wr_data      (cfg_wr_data),
        .cfg_wr_ready     (cfg_wr_ready),
        .cfg_commit       (cfg_commit),
        .cfg_busy         (cfg_busy),
        .cfg_done         (cfg_done),
        .cfg_commit_count (cfg_commit_count),
        .mon_tvalid       (mon_tvalid),
        .mon_tready       (mon_tready),
        .mon_tlast        (mon_tlast),
        .gate_stall       (gate_stall),
        .vlan_config_sel  (vlan_config_sel),
        .vlan_config_regs (vlan_config_regs),
        .vlan_cam_values  (vlan_cam_values)
    );

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic write_shadow(input logic sel, input int id, input logic [17:0] data);
        cfg_wr_en   = 1'b1;
        cfg_wr_sel  = sel;
        cfg_wr_id   = AW'(id);
        cfg_wr_data = data;
        tick();
        cfg_wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        cfg_wr_en = 0; cfg_wr_sel = 0; cfg_wr_id = 0; cfg_wr_data = 0;
        cfg_commit = 0; mon_tvalid = 0; up_ready = 1; mon_tlast = 0;
        vlan_config_sel = 0;
        tick(); tick();
        aresetn = 1'b1;
        tick();
        checks++; if (cfg_wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cfg_wr_ready); end
        checks++; if ({cfg_busy, cfg_done, gate_stall} !== 3'b000) begin errors++; $display("FAIL reset_flags: busy/done/stall got %b want 000", {cfg_busy, cfg_done, gate_stall}); end
        checks++; if (cfg_commit_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", cfg_commit_count); end
        checks++; if (vlan_config_regs !== 18'd0) begin errors++; $display("FAIL reset_regs: got %h want 0", vlan_config_regs); end
        checks++; if (vlan_cam_values !== '0) begin errors++; $display("FAIL reset_cam: got %h want 0", vlan_cam_values); end
    endtask

    task automatic test_basic_commit();
        vlan_config_sel = 4'd3;
        write_shadow(1'b0, 3, 18'h20064);
        write_shadow(1'b1, 3, 18'h10064);
        checks++; if (vlan_config_regs !== 18'd0) begin errors++; $display("FAIL basic_shadow_only: got %h want 0", vlan_config_regs); end
        cfg_commit = 1'b1;
        tick();                                   // edge N
        cfg_commit = 1'b0;
        checks++; if ({cfg_busy, gate_stall, cfg_wr_ready} !== 3'b110) begin errors++; $display("FAIL basic_pend: busy/stall/ready got %b want 110", {cfg_busy, gate_stall, cfg_wr_ready}); end
        checks++; if (vlan_config_regs !== 18'd0) begin errors++; $display("FAIL basic_before_copy: got %h want 0", vlan_config_regs); end
        tick();                                   // edge N+1: copy
        checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", cfg_done); end
        checks++; if (vlan_config_regs !== 18'h20064) begin errors++; $display("FAIL basic_regs: got %h want 20064", vlan_config_regs); end
        checks++; if (vlan_cam_values[67:51] !== 17'h10064) begin errors++; $display("FAIL basic_cam: got %h want 10064", vlan_cam_values[67:51]); end
        checks++; if (cfg_commit_count !== 8'd1) begin errors++; $display("FAIL basic_count: got %0d want 1", cfg_commit_count); end
        checks++; if ({cfg_busy, gate_stall} !== 2'b00) begin errors++; $display("FAIL basic_idle: busy/stall got %b want 00", {cfg_busy, gate_stall}); end
        tick();
        checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", cfg_done); end
    endtask

    task automatic test_mid_packet();
        vlan_config_sel = 4'd1;
        write_shadow(1'b0, 1, 18'h00005);
        mon_tvalid = 1'b1;
        for (int b = 1; b <= 5; b++) begin
            mon_tlast  = (b == 5);
            cfg_commit = (b == 2);
            tick();
            cfg_commit = 1'b0;
            if (b >= 2 && b <= 4) begin
                checks++; if ({cfg_busy, gate_stall} !== 2'b10) begin errors++; $display("FAIL mid_stall_b%0d: busy/stall got %b want 10", b, {cfg_busy, gate_stall}); end
                checks++; if (vlan_config_regs !== 18'd0) begin errors++; $display("FAIL mid_regs_b%0d: got %h want 0", b, vlan_config_regs); end
            end
        end
        mon_tvalid = 1'b0;
        mon_tlast  = 1'b0;
        checks++; if (gate_stall !== 1'b1) begin errors++; $display("FAIL mid_stall_after_last: got %b want 1", gate_stall); end
        checks++; if (vlan_config_regs !== 18'd0) begin errors++; $display("FAIL mid_regs_stall: got %h want 0", vlan_config_regs); end
        tick();
        checks++; if ({cfg_done, gate_stall} !== 2'b10) begin errors++; $display("FAIL mid_done: done/stall got %b want 10", {cfg_done, gate_stall}); end
        checks++; if (vlan_config_regs !== 18'h00005) begin errors++; $display("FAIL mid_regs_new: got %h want 00005", vlan_config_regs); end
        checks++; if (cfg_commit_count !== 8'd2) begin errors++; $display("FAIL mid_count: got %0d want 2", cfg_commit_count); end
        tick();
    endtask

    // Three-beat packets, tvalid held high; commit raised on beat 1 of A.
    task automatic test_back_to_back();
        logic [4:0] exp_stall;
        logic [4:0] exp_hs;
        logic       hs;
        int         beat;
        exp_stall = 5'b01000;   // bit c = cycle c
        exp_hs    = 5'b10111;
        beat = 0;
        vlan_config_sel = 4'd2;
        write_shadow(1'b0, 2, 18'h10022);
        mon_tvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            mon_tlast  = (beat == 2);
            cfg_commit = (c == 1);
            hs = mon_tvalid && mon_tready;
            checks++; if (gate_stall !== exp_stall[c]) begin errors++; $display("FAIL b2b_stall_c%0d: got %b want %b", c, gate_stall, exp_stall[c]); end
            checks++; if (hs !== exp_hs[c]) begin errors++; $display("FAIL b2b_hs_c%0d: got %b want %b", c, hs, exp_hs[c]); end
            if (c == 3) begin
                checks++; if (vlan_config_regs !== 18'd0) begin errors++; $display("FAIL b2b_regs_old: got %h want 0", vlan_config_regs); end
            end
            if (c == 4) begin
                checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b want 1", cfg_done); end
                checks++; if (vlan_config_regs !== 18'h10022) begin errors++; $display("FAIL b2b_regs_new: got %h want 10022", vlan_config_regs); end
            end
            tick();
            cfg_commit = 1'b0;
            if (hs) beat = (beat == 2) ? 0 : beat + 1;
        end
        // finish packet B (beat 1 and last beat 2)
        mon_tlast = 1'b0; tick();
        mon_tlast = 1'b1; tick();
        mon_tvalid = 1'b0; mon_tlast = 1'b0;
        tick();
        checks++; if (cfg_commit_count !== 8'd3) begin errors++; $display("FAIL b2b_count: got %0d want 3", cfg_commit_count); end
    endtask

    task automatic test_write_while_busy();
        vlan_config_sel = 4'd0;
        write_shadow(1'b0, 0, 18'h00ABC);
        mon_tvalid = 1'b1; mon_tlast = 1'b0;
        tick();                                    // in packet
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        checks++; if (cfg_wr_ready !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b want 0", cfg_wr_ready); end
        mon_tvalid = 1'b0;
        write_shadow(1'b0, 0, 18'h3FFFF);          // must be dropped
        mon_tvalid = 1'b1; mon_tlast = 1'b1;
        tick();
        mon_tvalid = 1'b0; mon_tlast = 1'b0;
        tick();                                    // copy
        checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL busy_done: got %b want 1", cfg_done); end
        checks++; if (vlan_config_regs !== 18'h00ABC) begin errors++; $display("FAIL busy_dropped_write: got %h want 00abc", vlan_config_regs); end
        tick();
    endtask

    task automatic test_simultaneous();
        cfg_wr_en = 1'b1; cfg_wr_sel = 1'b1; cfg_wr_id = 4'd15;
        cfg_wr_data = 18'h30FFF;                   // bit 17 is not stored in CAM
        cfg_commit = 1'b1;
        tick();
        cfg_wr_en = 1'b0; cfg_commit = 1'b0;
        tick();
        checks++; if (vlan_cam_values[17*15 +: 17] !== 17'h10FFF) begin errors++; $display("FAIL simul_cam15: got %h want 10fff", vlan_cam_values[17*15 +: 17]); end
        checks++; if (cfg_commit_count !== 8'd5) begin errors++; $display("FAIL simul_count: got %0d want 5", cfg_commit_count); end
        tick();
    endtask

    task automatic test_count_wrap();
        for (int k = 0; k < 250; k++) begin
            cfg_commit = 1'b1; tick();
            cfg_commit = 1'b0; tick();
        end
        checks++; if (cfg_commit_count !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d want 255", cfg_commit_count); end
        cfg_commit = 1'b1; tick();
        cfg_commit = 1'b0; tick();
        checks++; if (cfg_commit_count !== 8'd0) begin errors++; $display("FAIL wrap_0: got %0d want 0", cfg_commit_count); end
    endtask

    task automatic test_reset_in_pend();
        write_shadow(1'b0, 7, 18'h1ABCD);
        cfg_commit = 1'b1; tick();
        cfg_commit = 1'b0;
        checks++; if (cfg_busy !== 1'b1) begin errors++; $display("FAIL rstpend_busy: got %b want 1", cfg_busy); end
        #2;
        aresetn = 1'b0;
        #1;
        checks++; if ({cfg_wr_ready, cfg_busy, cfg_done, gate_stall} !== 4'b1000) begin errors++; $display("FAIL rstpend_flags: ready/busy/done/stall got %b want 1000", {cfg_wr_ready, cfg_busy, cfg_done, gate_stall}); end
        checks++; if (cfg_commit_count !== 8'd0) begin errors++; $display("FAIL rstpend_count: got %0d want 0", cfg_commit_count); end
        checks++; if (vlan_cam_values !== '0) begin errors++; $display("FAIL rstpend_cam: got %h want 0", vlan_cam_values); end
        tick();
        aresetn = 1'b1;
        vlan_config_sel = 4'd7;
        tick();
        checks++; if ({cfg_done, cfg_busy} !== 2'b00) begin errors++; $display("FAIL rstpend_no_done: done/busy got %b want 00", {cfg_done, cfg_busy}); end
        checks++; if (vlan_config_regs !== 18'd0) begin errors++; $display("FAIL rstpend_regs: got %h want 0", vlan_config_regs); end
        tick();
        checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL rstpend_no_done2: got %b want 0", cfg_done); end
    endtask

    initial begin
        test_reset();
        test_basic_commit();
        test_mid_packet();
        test_back_to_back();
        test_write_while_busy();
        test_simultaneous();
        test_count_wrap();
        test_reset_in_pend();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vlan_cfg_ctrl.md
# vlan_cfg_ctrl

Configuration controller for the VLAN parser. It holds the per-ID VLAN configuration registers and CAM entries in a shadow bank (written by software) and an active bank (read by the parser). A requested commit copies shadow to active only at a packet boundary of the parser's input stream, so a packet never sees its configuration change mid-flight. It sits beside the VLAN parser: it answers the parser's `vlan_config_sel` lookup, drives `vlan_cam_values`, and stalls the parser's upstream for one cycle to commit.

## Interface

Parameters:
- `AXIS_ID_WIDTH`, default 4: stream ID width.
- `NUM_AXIS_ID` (localparam) = 2**AXIS_ID_WIDTH: number of config/CAM entries.
- `EFF_ID_WIDTH` (localparam) = max(AXIS_ID_WIDTH, 1).

Ports (clock and reset first):
- `aclk`, in, 1: single clock.
- `aresetn`, in, 1: asynchronous, active-low reset.
- `cfg_wr_en`, in, 1: write strobe.
- `cfg_wr_sel`, in, 1: target select; 0 = config register, 1 = CAM entry.
- `cfg_wr_id`, in, EFF_ID_WIDTH: entry index.
- `cfg_wr_data`, in, 18: write data.
  - Config register layout: [15:0] VID, [16] VLAN enable, [17] ACL enable.
  - CAM layout: [15:0] VID, [16] valid; bit 17 is ignored.
- `cfg_wr_ready`, out, 1: writes are accepted only while high.
- `cfg_commit`, in, 1: pulse requesting a shadow→active copy.
- `cfg_busy`, out, 1: a commit is pending.
- `cfg_done`, out, 1: one-cycle pulse after a commit is applied.
- `cfg_commit_count`, out, 8: number of applied commits, wrapping.
- `mon_tvalid`, `mon_tready`, `mon_tlast`, in, 1 each: snoop of the parser input handshake. `mon_tready` is the already-gated tready.
- `gate_stall`, out, 1: upstream ANDs `!gate_stall` into the parser input tready.
- `vlan_config_sel`, in, EFF_ID_WIDTH: lookup index from the parser.
- `vlan_config_regs`, out, 18: active config entry at `vlan_config_sel`.
- `vlan_cam_values`, out, 17*NUM_AXIS_ID: active CAM entries; entry i occupies bits [17i+16:17i].

## Operation

- **Storage.** Shadow and active banks each hold NUM_AXIS_ID × 18-bit config registers and NUM_AXIS_ID × 17-bit CAM entries. All storage is flops.
- **Writes.** When `cfg_wr_en && cfg_wr_ready`, the shadow entry selected by `cfg_wr_sel`/`cfg_wr_id` takes `cfg_wr_data` at the clock edge. The active bank is never written directly.
- **`cfg_wr_ready`** = (state == IDLE). A write presented while not ready is dropped silently.
- **Packet tracking.** Register `in_pkt` is updated on each handshake (`mon_tvalid && mon_tready`):
  - set if `!mon_tlast`;
  - cleared if `mon_tlast`;
  - a single-beat packet leaves it 0.
- **State machine:**
  - IDLE: `cfg_commit` → PEND. The commit request is ignored in any other state.
  - PEND: if `in_pkt == 0` and there is no handshake this cycle → COMMIT action (copy all shadow to active, increment count) and return to IDLE. Otherwise stay in PEND.
- **`gate_stall`** = (state == PEND) && !in_pkt. This is combinational from registers only.
- **Protocol violation.** If a handshake still occurs while `gate_stall` is high, the copy is deferred and `in_pkt` updates normally.
- **`cfg_busy`** = (state == PEND).
- **`cfg_done`** is registered; it is high for exactly the one cycle after the copy edge.
- **Lookup.** `vlan_config_regs` = active_cfg[`vlan_config_sel`], combinational with zero latency. `vlan_cam_values` is driven straight from the active flops.
- **Simultaneous write and commit in IDLE.** The write lands in shadow on the same edge the state enters PEND, so it is included in that commit.
- **Shadow persistence.** Shadow is not cleared by a commit; after a commit, shadow equals active.
- **Reset.** Asserting `aresetn` low at any time, including during PEND, clears both banks, `in_pkt`, state (→ IDLE), and count. Any pending commit is discarded.

## Timing

- **Reset values:**
  - `cfg_wr_ready` = 1;
  - `cfg_busy`, `cfg_done`, `gate_stall` = 0;
  - `cfg_commit_count` = 0;
  - `vlan_config_regs` = 0;
  - `vlan_cam_values` = 0.
- **Minimum commit latency:**
  - `cfg_commit` sampled at edge N;
  - PEND during cycle N+1, with `gate_stall` high if idle;
  - copy at edge N+1;
  - new values visible and `cfg_done` = 1 in cycle N+2.
- **Mid-packet commit.** PEND persists until the edge that handshakes the `tlast` beat, plus one cycle. The commit lands in the cycle after `tlast`, and `gate_stall` is high for that single cycle.
- **Stall length.** `gate_stall` is high for at most 1 cycle per commit if upstream obeys it.
- **Count wrap.** `cfg_commit_count` wraps 255 → 0.

## Test plan

- **Reset and lookup.** After reset, write cfg id 3 = 0x2_0064 and CAM id 3 = 0x1_0064, commit while the stream is idle.
  - → `cfg_done` in cycle N+2; `vlan_config_regs` = 0x20064 with sel = 3; CAM bits [67:51] = 0x10064; count = 1.
- **Mid-packet commit.** Start a 5-beat packet, issue `cfg_commit` at beat 2.
  - → `gate_stall` low until `tlast` is handshaked, then high for 1 cycle.
  - → Active values unchanged until that cycle; `cfg_done` on the following cycle.
- **Back-to-back packets.** Run back-to-back packets with `tvalid` always high and commit issued mid-packet.
  - → The commit lands exactly between packets, and the second packet's first beat is delayed by 1 cycle.
- **Write while busy.** Hold PEND inside a packet and write cfg id 0 = 0x3FFFF.
  - → `cfg_wr_ready` = 0; after commit, cfg id 0 is still its prior shadow value.
- **Simultaneous write and commit.** Issue `cfg_wr_en` and `cfg_commit` in the same IDLE cycle, writing CAM id 15 = 0x1_0FFF.
  - → The committed CAM entry 15 = 0x10FFF.
- **Reset during PEND.** Drop `aresetn` while in PEND.
  - → All outputs return to reset values immediately; no `cfg_done`; count = 0.
